// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register-specifier width, ID/EX control bundle,
// and the ALU-operation / result-select encodings used by decoder and ALU.
package pipeline_pkg;

  localparam int unsigned REGW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  typedef struct packed {
    logic       RegWrite;
    logic       MemWrite;
    logic       Jump;
    logic       Branch;
    logic       ALUSrc;
    logic       Valid;
    logic [1:0] ResultSrc;
    logic [3:0] ALUControl;
  } idex_ctrl_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with async active-low reset, synchronous clear
// (priority) and load enable.
module pipe_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/idex_reg.sv
// ID/EX pipeline register: loads, holds or inserts a bubble each clock, and
// counts inserted bubbles with a saturating counter.
module idex_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] PCD,
  input  logic [WIDTH-1:0] ImmExtD,
  input  logic [WIDTH-1:0] PCPlus4D,
  input  logic [REGW-1:0]  Rs1D,
  input  logic [REGW-1:0]  Rs2D,
  input  logic [REGW-1:0]  RdD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic             ValidD,
  input  logic [1:0]       ResultSrcD,
  input  logic [3:0]       ALUControlD,
  input  logic             EnE,
  input  logic             FlushE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] PCE,
  output logic [WIDTH-1:0] ImmExtE,
  output logic [WIDTH-1:0] PCPlus4E,
  output logic [REGW-1:0]  Rs1E,
  output logic [REGW-1:0]  Rs2E,
  output logic [REGW-1:0]  RdE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic             ValidE,
  output logic [1:0]       ResultSrcE,
  output logic [3:0]       ALUControlE,
  output logic [CNTW-1:0]  BubbleCnt
);

  idex_ctrl_t ctrl_d, ctrl_q;

  always_comb begin
    ctrl_d            = '0;
    ctrl_d.RegWrite   = RegWriteD;
    ctrl_d.MemWrite   = MemWriteD;
    ctrl_d.Jump       = JumpD;
    ctrl_d.Branch     = BranchD;
    ctrl_d.ALUSrc     = ALUSrcD;
    ctrl_d.Valid      = ValidD;
    ctrl_d.ResultSrc  = ResultSrcD;
    ctrl_d.ALUControl = ALUControlD;
  end

  pipe_reg #(.W(WIDTH)) u_rd1 (.clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(RD1D),     .q(RD1E));
  pipe_reg #(.W(WIDTH)) u_rd2 (.clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(RD2D),     .q(RD2E));
  pipe_reg #(.W(WIDTH)) u_pc  (.clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(PCD),      .q(PCE));
  pipe_reg #(.W(WIDTH)) u_imm (.clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(ImmExtD),  .q(ImmExtE));
  pipe_reg #(.W(WIDTH)) u_pc4 (.clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(PCPlus4D), .q(PCPlus4E));

  // Specifiers clear on a bubble so forwarding never matches a stale register.
  pipe_reg #(.W(REGW)) u_rs1 (.clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(Rs1D), .q(Rs1E));
  pipe_reg #(.W(REGW)) u_rs2 (.clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(Rs2D), .q(Rs2E));
  pipe_reg #(.W(REGW)) u_rd  (.clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(RdD),  .q(RdE));

  pipe_reg #(.W($bits(idex_ctrl_t))) u_ctrl (
    .clk(clk), .rst_n(rst_n), .en(EnE), .clr(FlushE), .d(ctrl_d), .q(ctrl_q)
  );

  assign RegWriteE   = ctrl_q.RegWrite;
  assign MemWriteE   = ctrl_q.MemWrite;
  assign JumpE       = ctrl_q.Jump;
  assign BranchE     = ctrl_q.Branch;
  assign ALUSrcE     = ctrl_q.ALUSrc;
  assign ValidE      = ctrl_q.Valid;
  assign ResultSrcE  = ctrl_q.ResultSrc;
  assign ALUControlE = ctrl_q.ALUControl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          BubbleCnt <= '0;
    else if (FlushE && BubbleCnt != '1)  BubbleCnt <= BubbleCnt + 1'b1;
  end

  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown({EnE, FlushE}))
    else $error("EnE/FlushE unknown at clock edge");

endmodule

// File: tb/tb_idex_reg.sv
// Self-checking bench for idex_reg: directed table, reset corner cases and
// randomized traffic against a field-bundle reference model.
module tb_idex_reg;

  typedef struct packed {
    logic [31:0] rd1, rd2, pc, imm, pcp4;
    logic [4:0]  rs1, rs2, rd;
    logic        regwrite, memwrite, jump, branch, alusrc, valid;
    logic [1:0]  resultsrc;
    logic [3:0]  aluctrl;
  } fields_t;

  typedef struct {
    logic        en, fl;
    logic [31:0] rd2d;
    logic [4:0]  rdd;
    logic        rwd;
    logic [31:0] xrd2;
    logic [4:0]  xrd;
    logic        xrw;
    int unsigned xcnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic en, fl;
  fields_t d, qe, qe4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  fields_t     m;
  int unsigned mcnt, mcnt4;
  int unsigned n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  idex_reg dut (
    .clk(clk), .rst_n(rst_n),
    .RD1D(d.rd1), .RD2D(d.rd2), .PCD(d.pc), .ImmExtD(d.imm), .PCPlus4D(d.pcp4),
    .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
    .RegWriteD(d.regwrite), .MemWriteD(d.memwrite), .JumpD(d.jump), .BranchD(d.branch),
    .ALUSrcD(d.alusrc), .ValidD(d.valid), .ResultSrcD(d.resultsrc), .ALUControlD(d.aluctrl),
    .EnE(en), .FlushE(fl),
    .RD1E(qe.rd1), .RD2E(qe.rd2), .PCE(qe.pc), .ImmExtE(qe.imm), .PCPlus4E(qe.pcp4),
    .Rs1E(qe.rs1), .Rs2E(qe.rs2), .RdE(qe.rd),
    .RegWriteE(qe.regwrite), .MemWriteE(qe.memwrite), .JumpE(qe.jump), .BranchE(qe.branch),
    .ALUSrcE(qe.alusrc), .ValidE(qe.valid), .ResultSrcE(qe.resultsrc), .ALUControlE(qe.aluctrl),
    .BubbleCnt(cnt)
  );

  idex_reg #(.WIDTH(32), .CNTW(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .RD1D(d.rd1), .RD2D(d.rd2), .PCD(d.pc), .ImmExtD(d.imm), .PCPlus4D(d.pcp4),
    .Rs1D(d.rs1), .Rs2D(d.rs2), .RdD(d.rd),
    .RegWriteD(d.regwrite), .MemWriteD(d.memwrite), .JumpD(d.jump), .BranchD(d.branch),
    .ALUSrcD(d.alusrc), .ValidD(d.valid), .ResultSrcD(d.resultsrc), .ALUControlD(d.aluctrl),
    .EnE(en), .FlushE(fl),
    .RD1E(qe4.rd1), .RD2E(qe4.rd2), .PCE(qe4.pc), .ImmExtE(qe4.imm), .PCPlus4E(qe4.pcp4),
    .Rs1E(qe4.rs1), .Rs2E(qe4.rs2), .RdE(qe4.rd),
    .RegWriteE(qe4.regwrite), .MemWriteE(qe4.memwrite), .JumpE(qe4.jump), .BranchE(qe4.branch),
    .ALUSrcE(qe4.alusrc), .ValidE(qe4.valid), .ResultSrcE(qe4.resultsrc), .ALUControlE(qe4.aluctrl),
    .BubbleCnt(cnt4)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic randomize_d();
    d.rd1 = $urandom(); d.rd2 = $urandom(); d.pc = $urandom();
    d.imm = $urandom(); d.pcp4 = $urandom();
    d.rs1 = 5'($urandom()); d.rs2 = 5'($urandom()); d.rd = 5'($urandom());
    {d.regwrite, d.memwrite, d.jump, d.branch, d.alusrc, d.valid} = 6'($urandom());
    d.resultsrc = 2'($urandom()); d.aluctrl = 4'($urandom());
  endtask

  task automatic model_reset();
    m = '0; mcnt = 0; mcnt4 = 0;
  endtask

  // One clock: a flush bubbles everything and bumps the saturating counters,
  // otherwise an enable captures the decode bundle, otherwise nothing moves.
  task automatic step();
    @(posedge clk);
    if (fl) begin
      m = '0;
      if (mcnt  < 65535) mcnt++;
      if (mcnt4 < 15)    mcnt4++;
    end else if (en) begin
      m = d;
    end
    #1;
    check("e_fields",     qe,   m);
    check("e_fields_w4",  qe4,  m);
    check("bubble_cnt",   cnt,  mcnt);
    check("bubble_cnt_4", cnt4, mcnt4);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{en:1, fl:0, rd2d:32'hDEADBEEF, rdd:5'd7, rwd:1, xrd2:32'hDEADBEEF, xrd:5'd7, xrw:1, xcnt:0};
    tbl[1] = '{en:0, fl:0, rd2d:32'h12345678, rdd:5'd9, rwd:0, xrd2:32'hDEADBEEF, xrd:5'd7, xrw:1, xcnt:0};
    tbl[2] = '{en:0, fl:0, rd2d:32'h12345678, rdd:5'd9, rwd:0, xrd2:32'hDEADBEEF, xrd:5'd7, xrw:1, xcnt:0};
    tbl[3] = '{en:0, fl:0, rd2d:32'h12345678, rdd:5'd9, rwd:0, xrd2:32'hDEADBEEF, xrd:5'd7, xrw:1, xcnt:0};
    tbl[4] = '{en:0, fl:1, rd2d:32'h12345678, rdd:5'd9, rwd:1, xrd2:32'h0,        xrd:5'd0, xrw:0, xcnt:1};

    // Reset state
    rst_n = 1'b0; en = 1'b0; fl = 1'b0; d = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_fields", qe,  256'd0);
    check("reset_cnt",    cnt, 256'd0);

    // Release with a load pending: PC appears exactly one edge later
    randomize_d();
    d.pc = 32'h100; en = 1'b1;
    #2 rst_n = 1'b1;
    #1 check("release_pre_edge_pc", qe.pc, 256'd0);
    step();
    check("release_pc", qe.pc, 256'h100);

    // Directed load / hold / flush-over-hold table
    for (int i = 0; i < 5; i++) begin
      randomize_d();
      en = tbl[i].en; fl = tbl[i].fl;
      d.rd2 = tbl[i].rd2d; d.rd = tbl[i].rdd; d.regwrite = tbl[i].rwd;
      step();
      check($sformatf("tbl%0d_rd2e", i),      qe.rd2,      tbl[i].xrd2);
      check($sformatf("tbl%0d_rde", i),       qe.rd,       tbl[i].xrd);
      check($sformatf("tbl%0d_regwritee", i), qe.regwrite, tbl[i].xrw);
      check($sformatf("tbl%0d_cnt", i),       cnt,         tbl[i].xcnt);
    end
    check("flush_all_zero", qe, 256'd0);

    // Saturation on the 4-bit counter instance
    fl = 1'b0;
    for (int i = 0; i < 20; i++) begin
      randomize_d();
      en = 1'($urandom()); fl = 1'b1;
      step();
    end
    check("sat_cnt4", cnt4, 256'd15);
    fl = 1'b0; en = 1'b1;
    step();
    check("sat_cnt4_hold", cnt4, 256'd15);

    // Async reset between edges discards state immediately
    randomize_d();
    d.rd1 = 32'hA5A5A5A5; en = 1'b1; fl = 1'b0;
    step();
    check("pre_reset_rd1", qe.rd1, 256'hA5A5A5A5);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rd1",  qe.rd1, 256'd0);
    check("async_cnt",  cnt,    256'd0);
    check("async_cnt4", cnt4,   256'd0);
    randomize_d(); fl = 1'b1;
    @(posedge clk); #1;
    check("reset_held_fields", qe,  256'd0);
    check("reset_held_cnt",    cnt, 256'd0);
    fl = 1'b0;
    #4 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      randomize_d();
      en = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idex_reg.md
IDEX_REG -- requirements
Module: idex_reg

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, datapath width.
REQ-002 SHALL expose parameter CNTW, default 16, bubble-counter width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports RD1D, RD2D, PCD, ImmExtD, PCPlus4D  input  WIDTH each  decode-stage operands, PC and immediate.
REQ-006 SHALL have ports Rs1D, Rs2D, RdD  input  5 each  register specifiers.
REQ-007 SHALL have ports RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD  input  1 each  decode control and valid.
REQ-008 SHALL have ports ResultSrcD  input  2 and ALUControlD  input  4  result-select and ALU-operation codes.
REQ-009 SHALL have port EnE  input  1  load enable; 0 holds the register contents.
REQ-010 SHALL have port FlushE  input  1  bubble insert from the hazard unit.
REQ-011 SHALL have E-suffixed outputs matching every D-suffixed input: same widths, registered copies.
REQ-012 SHALL have port BubbleCnt  output  CNTW  count of bubbles inserted since reset.

Function
REQ-013 SHALL update all E outputs only on rising clk; no combinational path from D inputs to E outputs.
REQ-014 SHALL load every D field into its E output when EnE=1 and FlushE=0.
REQ-015 SHALL keep every E output unchanged when EnE=0 and FlushE=0.
REQ-016 SHALL, when FlushE=1, load a bubble regardless of EnE: all data fields, Rs1E/Rs2E/RdE and all control outputs set to 0, including ValidE.
REQ-017 SHALL zero Rs1E/Rs2E/RdE on a bubble so the forwarding logic never matches x0-forwarded data; a forwarded select of 2'b00 then passes RD2E unchanged.
REQ-018 SHALL increment BubbleCnt by 1 on each clock where FlushE=1.
REQ-019 SHALL saturate BubbleCnt at 2^CNTW-1; no wrap-around.
REQ-020 SHALL give each clock exactly one outcome from flush, load or hold; latency D to E is exactly one clock.
REQ-021 SHALL treat an X on EnE or FlushE as a bench error; behaviour is only defined for 0/1.

Reset
REQ-022 SHALL, on rst_n low, clear every E output and BubbleCnt to 0 immediately, independent of clk.
REQ-023 SHALL hold the reset state while rst_n is low; the first load occurs on the first rising clk after rst_n is released.
REQ-024 SHALL discard any in-flight load, hold or flush when reset asserts mid-operation; no state survives.

Structure
REQ-025 SHALL take the idex_ctrl_t struct (RegWrite, MemWrite, Jump, Branch, ALUSrc, Valid, ResultSrc, ALUControl) and the REGW=5 constant from the shared package pipeline_pkg.
REQ-026 SHALL place the ALUControl and ResultSrc encodings in pipeline_pkg, shared with the decoder and ALU.
REQ-027 SHALL build each field from one sub-module, pipe_reg #(W), with clk, rst_n, en, clr, d and q; clr has priority over en.

Verification
REQ-028 SHALL pass a load test: EnE=1, RD2D=32'hDEADBEEF, RdD=5'd7, RegWriteD=1 -> next clock RD2E=32'hDEADBEEF, RdE=7, RegWriteE=1.
REQ-029 SHALL pass a hold test: after the load, EnE=0 and RD2D=32'h12345678 for 3 clocks -> RD2E stays 32'hDEADBEEF.
REQ-030 SHALL pass a flush-over-hold test: EnE=0, FlushE=1 -> next clock all E outputs 0 and BubbleCnt increments from 0 to 1.
REQ-031 SHALL pass a saturation test: CNTW=4, FlushE=1 for 20 clocks -> BubbleCnt reaches 15 and stays 15.
REQ-032 SHALL pass an async-reset test: rst_n driven low between clock edges while RD1E=32'hA5A5A5A5 -> RD1E=0 and BubbleCnt=0 before the next edge.
REQ-033 SHALL pass a release test: rst_n released with EnE=1 and PCD=32'h100 -> PCE=32'h100 exactly one edge later.
